// File: rtl/minesweeper_reveal_ctrl.sv
// minesweeper_reveal_ctrl: flood-fill reveal engine for a 16x16 board.
// Walks a synchronous cell memory breadth-first from a start cell.
// Ports: clk, rst_n (async, active low); start/start_pos request;
//   busy, done (1-cycle pulse), hit_bomb status;
//   mem_addr/mem_rd_en/mem_rdata (1-cycle read latency),
//   mem_wr_en/mem_wdata write port; revealed_count.
// Cell word: [5] bomb, [4:2] adjacent count, [1] flagged, [0] covered.
// Optional: define REVEAL_STATS_EN to build the revealed_count counter;
//   otherwise revealed_count is tied to 0.
module minesweeper_reveal_ctrl #(
  parameter int QUEUE_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] start_pos,
  output logic       busy,
  output logic       done,
  output logic       hit_bomb,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [5:0] mem_rdata,
  output logic       mem_wr_en,
  output logic [5:0] mem_wdata,
  output logic [8:0] revealed_count
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_START,
    S_POP,
    S_NBR_RD,
    S_NBR_CHK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]    r_start;
  logic [7:0]    r_cur;
  logic [2:0]    r_idx;
  logic          r_hit;
  logic [7:0]    r_fifo [QUEUE_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_fcnt;

  logic       w_go;
  logic       w_rd;
  logic       w_wr;
  logic [7:0] w_addr;
  logic [5:0] w_wdata;
  logic       w_push;
  logic [7:0] w_push_pos;
  logic       w_pop;
  logic       w_set_hit;
  logic       w_idx_inc;
  logic       w_nbr_ok;
  logic [7:0] w_nbr_off;
  logic [7:0] w_nbr_addr;
  logic       w_up;
  logic       w_dn;
  logic       w_lf;
  logic       w_rt;
  logic       w_open;
  logic       w_adj0;

  assign w_up = (r_cur[7:4] != 4'd0);
  assign w_dn = (r_cur[7:4] != 4'd15);
  assign w_lf = (r_cur[3:0] != 4'd0);
  assign w_rt = (r_cur[3:0] != 4'd15);

  // Offsets as 8-bit two's complement; the edge
  // mask guarantees the sum never wraps the board.
  always_comb begin
    w_nbr_ok  = 1'b0;
    w_nbr_off = 8'h00;
    unique case (r_idx)
      3'd0: begin w_nbr_ok = w_up && w_lf; w_nbr_off = 8'hEF; end
      3'd1: begin w_nbr_ok = w_up;         w_nbr_off = 8'hF0; end
      3'd2: begin w_nbr_ok = w_up && w_rt; w_nbr_off = 8'hF1; end
      3'd3: begin w_nbr_ok = w_lf;         w_nbr_off = 8'hFF; end
      3'd4: begin w_nbr_ok = w_rt;         w_nbr_off = 8'h01; end
      3'd5: begin w_nbr_ok = w_dn && w_lf; w_nbr_off = 8'h0F; end
      3'd6: begin w_nbr_ok = w_dn;         w_nbr_off = 8'h10; end
      3'd7: begin w_nbr_ok = w_dn && w_rt; w_nbr_off = 8'h11; end
    endcase
  end

  assign w_nbr_addr = r_cur + w_nbr_off;
  assign w_open     = mem_rdata[0] && !mem_rdata[1];
  assign w_adj0     = (mem_rdata[4:2] == 3'd0);

  always_comb begin
    w_next     = r_state;
    w_go       = 1'b0;
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_addr     = 8'h00;
    w_wdata    = 6'h00;
    w_push     = 1'b0;
    w_push_pos = 8'h00;
    w_pop      = 1'b0;
    w_set_hit  = 1'b0;
    w_idx_inc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // rst_n gate keeps the read port quiet while held in reset
        if (start && rst_n) begin
          w_go   = 1'b1;
          w_rd   = 1'b1;
          w_addr = start_pos;
          w_next = S_CHK_START;
        end
      end
      S_CHK_START: begin
        w_next = S_DONE;
        if (w_open) begin
          w_wr    = 1'b1;
          w_addr  = r_start;
          w_wdata = {mem_rdata[5:1], 1'b0};
          if (mem_rdata[5]) begin
            w_set_hit = 1'b1;
          end else begin
            w_push     = w_adj0;
            w_push_pos = r_start;
            w_next     = S_POP;
          end
        end
      end
      S_POP: begin
        if (r_fcnt == '0) begin
          w_next = S_DONE;
        end else begin
          w_pop  = 1'b1;
          w_next = S_NBR_RD;
        end
      end
      S_NBR_RD: begin
        if (w_nbr_ok) begin
          w_rd   = 1'b1;
          w_addr = w_nbr_addr;
          w_next = S_NBR_CHK;
        end else if (r_idx == 3'd7) begin
          w_next = S_POP;
        end else begin
          w_idx_inc = 1'b1;
        end
      end
      S_NBR_CHK: begin
        if (w_open && !mem_rdata[5]) begin
          w_wr       = 1'b1;
          w_addr     = w_nbr_addr;
          w_wdata    = {mem_rdata[5:1], 1'b0};
          w_push     = w_adj0;
          w_push_pos = w_nbr_addr;
        end
        if (r_idx == 3'd7) begin
          w_next = S_POP;
        end else begin
          w_idx_inc = 1'b1;
          w_next    = S_NBR_RD;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_start <= 8'h00;
      r_cur   <= 8'h00;
      r_idx   <= 3'd0;
      r_hit   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_start <= start_pos;
        r_hit   <= 1'b0;
      end else if (w_set_hit) begin
        r_hit <= 1'b1;
      end
      if (w_pop) begin
        r_cur  <= r_fifo[r_rptr];
        r_rptr <= r_rptr + PTR_ONE;
        r_idx  <= 3'd0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      // push and pop never fall in the same state
      if (w_push) begin
        r_fcnt <= r_fcnt + CNT_ONE;
      end else if (w_pop) begin
        r_fcnt <= r_fcnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_push_pos;
    end
  end

`ifdef REVEAL_STATS_EN
  logic [8:0] r_cnt;

  // every write except the bomb write uncovers one safe cell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 9'd0;
    end else if (w_go) begin
      r_cnt <= 9'd0;
    end else if (w_wr && !w_set_hit) begin
      r_cnt <= r_cnt + 9'd1;
    end
  end

  assign revealed_count = r_cnt;
`else
  assign revealed_count = 9'd0;
`endif

  assign busy      = (r_state == S_CHK_START) || (r_state == S_POP) ||
                     (r_state == S_NBR_RD) || (r_state == S_NBR_CHK);
  assign done      = (r_state == S_DONE);
  assign hit_bomb  = r_hit;
  assign mem_addr  = w_addr;
  assign mem_rd_en = w_rd;
  assign mem_wr_en = w_wr;
  assign mem_wdata = w_wdata;

endmodule

// File: tb/tb_minesweeper_reveal_ctrl.sv
// tb_minesweeper_reveal_ctrl: directed bench with a flood-fill model
// on a row/col grid and a per-cycle memory-port monitor.
module tb_minesweeper_reveal_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] start_pos = 8'h00;
  logic       busy;
  logic       done;
  logic       hit_bomb;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [5:0] mem_rdata = 6'h00;
  logic       mem_wr_en;
  logic [5:0] mem_wdata;
  logic [8:0] revealed_count;

  minesweeper_reveal_ctrl #(.QUEUE_DEPTH(256)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .start_pos(start_pos),
    .busy(busy),
    .done(done),
    .hit_bomb(hit_bomb),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .revealed_count(revealed_count)
  );

  always #5 clk = ~clk;

  logic [5:0] board [256];
  int         wcnt [256];
  bit         acc [256];

  logic [5:0] init_b [256];
  logic [5:0] exp_b [256];
  bit         exp_allowed [256];
  bit         exp_hit;
  int         exp_cnt;
  bit         mon_en = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= board[mem_addr];
      acc[mem_addr] <= 1'b1;
    end
    if (mem_wr_en) begin
      board[mem_addr] <= mem_wdata;
      wcnt[mem_addr] <= wcnt[mem_addr] + 1;
      acc[mem_addr] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_rc();
`ifdef REVEAL_STATS_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("rd_wr_exclusive", int'(mem_rd_en && mem_wr_en), 0);
      if (mem_rd_en)
        chk($sformatf("rd_allowed[%02h]", mem_addr),
            int'(exp_allowed[mem_addr]), 1);
      if (mem_wr_en) begin
        chk($sformatf("wr_data[%02h]", mem_addr), int'(mem_wdata),
            int'({board[mem_addr][5:1], 1'b0}));
        chk($sformatf("wr_once[%02h]", mem_addr), wcnt[mem_addr], 0);
        chk($sformatf("wr_expected[%02h]", mem_addr),
            int'(init_b[mem_addr][0] && !exp_b[mem_addr][0]), 1);
      end
    end
  end

  task automatic fill(input logic [5:0] v);
    for (int i = 0; i < 256; i++) init_b[i] = v;
  endtask

  task automatic load_board();
    for (int i = 0; i < 256; i++) begin
      board[i] <= init_b[i];
      wcnt[i] <= 0;
      acc[i] <= 1'b0;
    end
    #1;
  endtask

  task automatic model(input int s);
    int q[$];
    int p, r, c, nr, nc, n;
    for (int i = 0; i < 256; i++) begin
      exp_b[i] = init_b[i];
      exp_allowed[i] = 1'b0;
    end
    exp_hit = 1'b0;
    exp_cnt = 0;
    exp_allowed[s] = 1'b1;
    if (exp_b[s][0] && !exp_b[s][1]) begin
      exp_b[s][0] = 1'b0;
      if (exp_b[s][5]) begin
        exp_hit = 1'b1;
      end else begin
        exp_cnt = 1;
        if (exp_b[s][4:2] == 3'd0) q.push_back(s);
      end
    end
    while (q.size() > 0) begin
      p = q.pop_front();
      r = p / 16;
      c = p % 16;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          nr = r + dr;
          nc = c + dc;
          if ((dr != 0 || dc != 0) && nr >= 0 && nr < 16 &&
              nc >= 0 && nc < 16) begin
            n = nr * 16 + nc;
            exp_allowed[n] = 1'b1;
            if (exp_b[n][0] && !exp_b[n][1] && !exp_b[n][5]) begin
              exp_b[n][0] = 1'b0;
              exp_cnt++;
              if (exp_b[n][4:2] == 3'd0) q.push_back(n);
            end
          end
        end
      end
    end
  endtask

  function automatic int total_writes();
    int t = 0;
    for (int i = 0; i < 256; i++) t += wcnt[i];
    return t;
  endfunction

  task automatic run_op(input logic [7:0] p, input int lat,
                        input bit inject);
    int k;
    model(int'(p));
    load_board();
    @(negedge clk);
    start = 1'b1;
    start_pos = p;
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    chk("busy_after_start", int'(busy), 1);
    while (!done && k < 20000) begin
      start = 1'b0;
      if (inject && k == 3) begin
        start = 1'b1;
        start_pos = 8'h88;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("done_seen", int'(done), 1);
    if (lat > 0) chk("done_latency", k, lat);
    chk("busy_at_done", int'(busy), 0);
    chk("hit_bomb", int'(hit_bomb), int'(exp_hit));
    chk("revealed_count", int'(revealed_count), exp_rc());
    @(negedge clk);
    chk("done_one_pulse", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    chk("hit_bomb_hold", int'(hit_bomb), int'(exp_hit));
    chk("count_hold", int'(revealed_count), exp_rc());
    for (int i = 0; i < 256; i++)
      chk($sformatf("board[%02h]", i), int'(board[i]), int'(exp_b[i]));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_hit"}, int'(hit_bomb), 0);
    chk({tag, "_rd"}, int'(mem_rd_en), 0);
    chk({tag, "_wr"}, int'(mem_wr_en), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_count"}, int'(revealed_count), 0);
  endtask

  initial begin
    start = 1'b1;
    start_pos = 8'h5A;
    #12;
    chk_reset_outs("reset");
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // whole board empty: everything opens
    fill(6'b000001);
    run_op(8'h00, 0, 1'b0);
    chk("model_full_cnt", exp_cnt, 256);
    chk("full_writes", total_writes(), 256);

    // bomb at start
    fill(6'b000101);
    init_b[8'h37] = 6'b100001;
    run_op(8'h37, 2, 1'b0);
    chk("bomb_model_hit", int'(exp_hit), 1);
    chk("bomb_word", int'(board[8'h37]), 6'b100000);
    chk("bomb_writes", total_writes(), 1);

    // already uncovered start
    fill(6'b000101);
    init_b[8'h10] = 6'b000100;
    run_op(8'h10, 2, 1'b0);
    chk("open_writes", total_writes(), 0);

    // flag and numbered border, plus a start while busy
    fill(6'b000101);
    init_b[8'h00] = 6'b000001;
    init_b[8'h01] = 6'b000011;
    init_b[8'h10] = 6'b001001;
    init_b[8'h11] = 6'b000101;
    run_op(8'h00, 0, 1'b1);
    chk("flag_model_cnt", exp_cnt, 3);
    chk("flag_untouched", wcnt[8'h01], 0);
    chk("flag_writes", total_writes(), 3);
    chk("busy_start_ignored", wcnt[8'h88], 0);

    // bottom-right corner must not wrap
    fill(6'b000101);
    init_b[8'hFF] = 6'b000001;
    run_op(8'hFF, 0, 1'b0);
    chk("wrap_model_cnt", exp_cnt, 4);
    chk("wrap_ee", int'(board[8'hEE]), 6'b000100);
    chk("wrap_writes", total_writes(), 4);
    chk("wrap_no_00", int'(acc[8'h00]), 0);
    chk("wrap_no_0f", int'(acc[8'h0F]), 0);

    // reset in the middle of a flood
    fill(6'b000001);
    model(0);
    load_board();
    @(negedge clk);
    start = 1'b1;
    start_pos = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h00, 0, 1'b0);
    chk("after_reset_writes", total_writes(), 256);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/minesweeper_reveal_ctrl.md
MINESWEEPER_REVEAL_CTRL -- requirements
Module: minesweeper_reveal_ctrl

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 256, pending-position FIFO depth (power of two, >=256 for a 16x16 board).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  request reveal; start_pos  in  8  cell index {row[7:4],col[3:0]}.
REQ-004 SHALL have ports: busy  out  1  operation in progress; done  out  1  one-cycle completion pulse; hit_bomb  out  1  start cell was a bomb.
REQ-005 SHALL have ports: mem_addr  out  8; mem_rd_en  out  1; mem_rdata  in  6, valid one cycle after mem_rd_en; mem_wr_en  out  1; mem_wdata  out  6.
REQ-006 SHALL have port: revealed_count  out  9  cells uncovered by the current/last operation.
REQ-007 SHALL interpret cell word bits as: [5] bomb, [4:2] adjacent-bomb count, [1] flagged, [0] covered.

Function
REQ-008 SHALL implement states IDLE, CHK_START, POP, NBR_RD, NBR_CHK, DONE.
REQ-009 In IDLE, start=1 SHALL latch start_pos, issue a read of it, clear revealed_count and hit_bomb, assert busy, and go to CHK_START; start while busy=1 SHALL be ignored.
REQ-010 CHK_START: uncovered or flagged cell SHALL go to DONE with no write.
REQ-011 CHK_START: covered unflagged bomb SHALL write the word with [0] cleared, set hit_bomb, go to DONE.
REQ-012 CHK_START: covered unflagged safe cell SHALL write with [0] cleared, increment revealed_count, push start_pos if [4:2]==0, go to POP.
REQ-013 POP: empty FIFO SHALL go to DONE; else pop to cur, neighbour index 0, go to NBR_RD.
REQ-014 Neighbour order SHALL be offsets -17,-16,-15,-1,+1,+15,+16,+17; offsets off the board (row 0 up, row 15 down, col 0 left, col 15 right) SHALL be skipped at one cycle each, no memory access.
REQ-015 NBR_RD SHALL read cur+offset; NBR_CHK SHALL, if covered, unflagged and not bomb, write with [0] cleared, increment revealed_count, and push if [4:2]==0.
REQ-016 After neighbour index 7 SHALL return to POP.
REQ-017 A cell SHALL be pushed only on its covered-to-uncovered write, so each cell is queued at most once and the FIFO never overflows.
REQ-018 mem_wr_en and mem_rd_en SHALL never be asserted in the same cycle; mem_wdata SHALL equal the just-read word with only bit [0] changed.
REQ-019 DONE SHALL pulse done for exactly one cycle, deassert busy in the same cycle, and return to IDLE; hit_bomb and revealed_count SHALL hold until the next accepted start.
REQ-020 Neighbour address arithmetic SHALL be 8-bit; edge masking guarantees no wrap is ever issued.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, empty the FIFO, and drive busy, done, hit_bomb, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, revealed_count to 0, including mid-operation (partial board writes are not undone).

Configuration
REQ-022 With REVEAL_STATS_EN defined, revealed_count SHALL operate per REQ-009/012/015; without it revealed_count SHALL be constant 0 and its counter SHALL not be synthesized.

Verification
REQ-023 All cells covered, adj=0, no bombs, start_pos=0x00 -> all 256 cells uncovered, revealed_count=256, hit_bomb=0, single done pulse.
REQ-024 start_pos=0x37 holds a bomb -> one write to 0x37 with [0]=0, hit_bomb=1, done 2 cycles after start, revealed_count=0.
REQ-025 start_pos=0x10 already uncovered -> no writes, done pulse, revealed_count=0.
REQ-026 Start at 0x00 (adj=0) with 0x01 flagged, 0x10 adj=2, 0x11 adj=1 -> only 0x00, 0x10, 0x11 written; 0x01 untouched; revealed_count=3.
REQ-027 Start at 0xFF (adj=0, rest adj=1) -> only 0xFE, 0xEF, 0xEE, 0xFF revealed; no access to 0x00 or 0x0F (wrap check).
REQ-028 Assert rst_n low mid-flood, then start at 0x00 -> busy=0 at once, then a clean full operation with correct done.
